// File: rtl/frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : frame_sequencer_if
// Brief   : Command/strobe inputs and frame status outputs of frame_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface frame_sequencer_if #(
    parameter int FRAME_BITS = 9,
    parameter int LEN_W      = 16,
    parameter int BIT_W      = $clog2(FRAME_BITS)
);
    logic             i_en;
    logic             i_scl_neg_edge;
    logic             i_cmd_attr;
    logic [LEN_W-1:0] i_data_len;
    logic [2:0]       i_dtt;
    logic             i_direct;
    logic             i_term;

    logic             o_busy;
    logic [BIT_W-1:0] o_bit_idx;
    logic [LEN_W:0]   o_frames_left;
    logic             o_last_bit;
    logic             o_last_frame;
    logic             o_done;
    logic             o_early_term;
    logic             o_zero_len;

    modport master (
        output i_en, i_scl_neg_edge, i_cmd_attr, i_data_len, i_dtt, i_direct, i_term,
        input  o_busy, o_bit_idx, o_frames_left, o_last_bit, o_last_frame,
               o_done, o_early_term, o_zero_len
    );

    modport slave (
        input  i_en, i_scl_neg_edge, i_cmd_attr, i_data_len, i_dtt, i_direct, i_term,
        output o_busy, o_bit_idx, o_frames_left, o_last_bit, o_last_frame,
               o_done, o_early_term, o_zero_len
    );
endinterface
`default_nettype wire

// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : frame_sequencer
// Brief   : Counts SCL bit periods into frames and frames into an I3C transfer.
// Revision: 1.0 - initial release
// ============================================================================
module frame_sequencer #(
    parameter int FRAME_BITS = 9,
    parameter int LEN_W      = 16,
    parameter int BIT_W      = $clog2(FRAME_BITS)
) (
    input  wire               i_sys_clk,
    input  wire               i_rst,
    frame_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [BIT_W-1:0] c_LAST_BIT = BIT_W'(FRAME_BITS - 1);
    localparam logic [LEN_W:0]   c_FL_ONE   = (LEN_W+1)'(1);

    state_t           state_q;
    logic             busy_q;
    logic [BIT_W-1:0] bit_idx_q;
    logic [LEN_W:0]   frames_left_q;
    logic             done_q;
    logic             early_term_q;
    logic             zero_len_q;

    logic [2:0]       w_imm_frames;
    logic [LEN_W:0]   w_total;

    // DTT 5..7 carry one defining byte plus DTT-4 data frames.
    always_comb begin
        w_imm_frames = (bus.i_dtt <= 3'd4) ? bus.i_dtt : (bus.i_dtt - 3'd3);
        w_total      = '0;
        if (bus.i_cmd_attr) begin
            w_total = (LEN_W+1)'(w_imm_frames) + (LEN_W+1)'(bus.i_direct);
        end else begin
            w_total = (LEN_W+1)'(bus.i_data_len) + (LEN_W+1)'(bus.i_direct);
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            bit_idx_q     <= '0;
            frames_left_q <= '0;
            done_q        <= 1'b0;
            early_term_q  <= 1'b0;
            zero_len_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.i_en) begin
                        frames_left_q <= w_total;
                        bit_idx_q     <= '0;
                        early_term_q  <= 1'b0;
                        if (w_total == '0) begin
                            zero_len_q <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            zero_len_q <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= S_COUNT;
                        end
                    end
                end
                S_COUNT: begin
                    // Abort beats a coincident strobe: counters keep their values.
                    if (!bus.i_en) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (bus.i_scl_neg_edge) begin
                        if (bit_idx_q < c_LAST_BIT) begin
                            bit_idx_q <= bit_idx_q + BIT_W'(1);
                        end else begin
                            bit_idx_q     <= '0;
                            frames_left_q <= frames_left_q - c_FL_ONE;
                            if (frames_left_q == c_FL_ONE) begin
                                busy_q  <= 1'b0;
                                state_q <= S_DONE;
                            end else if (bus.i_term) begin
                                busy_q       <= 1'b0;
                                early_term_q <= 1'b1;
                                state_q      <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    done_q <= 1'b0;
                    if (!bus.i_en) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy        = busy_q;
    assign bus.o_bit_idx     = bit_idx_q;
    assign bus.o_frames_left = frames_left_q;
    assign bus.o_done        = done_q;
    assign bus.o_early_term  = early_term_q;
    assign bus.o_zero_len    = zero_len_q;
    assign bus.o_last_bit    = (state_q == S_COUNT) && (bit_idx_q == c_LAST_BIT);
    assign bus.o_last_frame  = (state_q == S_COUNT) && (frames_left_q == c_FL_ONE);

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_frame_sequencer
// Brief   : Directed self-checking bench for frame_sequencer (9- and 18-bit frames).
// Revision: 1.0 - initial release
// ============================================================================
module tb_frame_sequencer;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    frame_sequencer_if #(.FRAME_BITS(9),  .LEN_W(16)) bus_a ();
    frame_sequencer_if #(.FRAME_BITS(18), .LEN_W(16)) bus_b ();

    frame_sequencer #(.FRAME_BITS(9),  .LEN_W(16)) u_dut_a (.i_sys_clk(clk), .i_rst(rst_a), .bus(bus_a));
    frame_sequencer #(.FRAME_BITS(18), .LEN_W(16)) u_dut_b (.i_sys_clk(clk), .i_rst(rst_b), .bus(bus_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic attr, input logic [15:0] len, input logic [2:0] dtt, input logic dir);
        bus_a.i_cmd_attr = attr; bus_a.i_data_len = len; bus_a.i_dtt = dtt; bus_a.i_direct = dir;
        bus_a.i_en = 1'b1;
        tick();
    endtask

    task automatic strobe_a(input logic t);
        bus_a.i_scl_neg_edge = 1'b1; bus_a.i_term = t;
        tick();
        bus_a.i_scl_neg_edge = 1'b0; bus_a.i_term = 1'b0;
    endtask

    task automatic strobe_b();
        bus_b.i_scl_neg_edge = 1'b1;
        tick();
        bus_b.i_scl_neg_edge = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        tick(); tick();
        n_checks++;
        if ({bus_a.o_busy, bus_a.o_bit_idx, bus_a.o_frames_left, bus_a.o_last_bit, bus_a.o_last_frame,
             bus_a.o_done, bus_a.o_early_term, bus_a.o_zero_len} !== '0) begin
            n_errors++;
            $display("FAIL reset_a: busy=%b bit=%0d fl=%0d done=%b et=%b zl=%b, expected all 0",
                     bus_a.o_busy, bus_a.o_bit_idx, bus_a.o_frames_left, bus_a.o_done, bus_a.o_early_term, bus_a.o_zero_len);
        end
        n_checks++;
        if ({bus_b.o_busy, bus_b.o_bit_idx, bus_b.o_frames_left, bus_b.o_done, bus_b.o_zero_len} !== '0) begin
            n_errors++;
            $display("FAIL reset_b: busy=%b bit=%0d fl=%0d, expected all 0", bus_b.o_busy, bus_b.o_bit_idx, bus_b.o_frames_left);
        end
        rst_a = 1'b0; rst_b = 1'b0;
        tick();
    endtask

    task automatic test_regular_broadcast();
        int ebit, efl, seen;
        logic ebusy, elf, elb;
        start_a(1'b0, 16'd2, 3'd0, 1'b0);
        n_checks++;
        if (bus_a.o_busy !== 1'b1 || bus_a.o_frames_left !== 17'd2 || bus_a.o_bit_idx !== 4'd0) begin
            n_errors++;
            $display("FAIL bcast_start: busy=%b fl=%0d bit=%0d, expected busy=1 fl=2 bit=0",
                     bus_a.o_busy, bus_a.o_frames_left, bus_a.o_bit_idx);
        end
        for (int k = 1; k <= 18; k++) begin
            strobe_a(1'b0);
            ebusy = (k < 18);
            ebit  = k % 9;
            efl   = 2 - k / 9;
            elf   = ebusy && (efl == 1);
            elb   = ebusy && (ebit == 8);
            n_checks++;
            if (bus_a.o_busy !== ebusy || bus_a.o_bit_idx !== 4'(ebit) || bus_a.o_frames_left !== 17'(efl) ||
                bus_a.o_last_frame !== elf || bus_a.o_last_bit !== elb || bus_a.o_done !== 1'b0) begin
                n_errors++;
                $display("FAIL bcast_strobe%0d: busy=%b bit=%0d fl=%0d lf=%b lb=%b done=%b, expected %b %0d %0d %b %b 0",
                         k, bus_a.o_busy, bus_a.o_bit_idx, bus_a.o_frames_left, bus_a.o_last_frame,
                         bus_a.o_last_bit, bus_a.o_done, ebusy, ebit, efl, elf, elb);
            end
        end
        tick();
        n_checks++;
        if (bus_a.o_done !== 1'b1 || bus_a.o_early_term !== 1'b0 || bus_a.o_zero_len !== 1'b0) begin
            n_errors++;
            $display("FAIL bcast_done: done=%b et=%b zl=%b, expected 1 0 0", bus_a.o_done, bus_a.o_early_term, bus_a.o_zero_len);
        end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus_a.o_done) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL bcast_done_width: extra done cycles=%0d, expected 0", seen);
        end
        bus_a.i_en = 1'b0;
        tick();
    endtask

    task automatic test_regular_direct();
        int ndone, nbusy;
        start_a(1'b0, 16'd5, 3'd0, 1'b1);
        bus_a.i_data_len = 16'd99;
        bus_a.i_direct   = 1'b0;
        n_checks++;
        if (bus_a.o_frames_left !== 17'd6) begin
            n_errors++;
            $display("FAIL direct_total: fl=%0d, expected 6", bus_a.o_frames_left);
        end
        for (int k = 1; k <= 53; k++) strobe_a(1'b0);
        n_checks++;
        if (bus_a.o_busy !== 1'b1 || bus_a.o_frames_left !== 17'd1 || bus_a.o_bit_idx !== 4'd8 ||
            bus_a.o_last_frame !== 1'b1 || bus_a.o_last_bit !== 1'b1) begin
            n_errors++;
            $display("FAIL direct_53: busy=%b fl=%0d bit=%0d lf=%b lb=%b, expected 1 1 8 1 1",
                     bus_a.o_busy, bus_a.o_frames_left, bus_a.o_bit_idx, bus_a.o_last_frame, bus_a.o_last_bit);
        end
        strobe_a(1'b0);
        ndone = 0; nbusy = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_a.o_done) ndone++;
            if (bus_a.o_busy) nbusy++;
        end
        n_checks++;
        if (ndone != 1 || nbusy != 0 || bus_a.o_frames_left !== 17'd0) begin
            n_errors++;
            $display("FAIL direct_hold: done pulses=%0d busy cycles=%0d fl=%0d, expected 1 0 0",
                     ndone, nbusy, bus_a.o_frames_left);
        end
        bus_a.i_en = 1'b0;
        tick();
    endtask

    task automatic test_dtt_sweep();
        int tbl [8] = '{0, 1, 2, 3, 4, 2, 3, 4};
        int exp_total;
        for (int d = 0; d < 8; d++) begin
            for (int dir = 0; dir < 2; dir++) begin
                exp_total = tbl[d] + dir;
                start_a(1'b1, 16'hFFFF, 3'(d), 1'(dir));
                n_checks++;
                if (bus_a.o_frames_left !== 17'(exp_total)) begin
                    n_errors++;
                    $display("FAIL dtt%0d_dir%0d_total: fl=%0d, expected %0d", d, dir, bus_a.o_frames_left, exp_total);
                end
                if (exp_total == 0) begin
                    n_checks++;
                    if (bus_a.o_busy !== 1'b0 || bus_a.o_zero_len !== 1'b1 || bus_a.o_done !== 1'b0) begin
                        n_errors++;
                        $display("FAIL zero_len_start: busy=%b zl=%b done=%b, expected 0 1 0",
                                 bus_a.o_busy, bus_a.o_zero_len, bus_a.o_done);
                    end
                    tick();
                    n_checks++;
                    if (bus_a.o_done !== 1'b1 || bus_a.o_busy !== 1'b0) begin
                        n_errors++;
                        $display("FAIL zero_len_done: done=%b busy=%b, expected 1 0", bus_a.o_done, bus_a.o_busy);
                    end
                    tick();
                    n_checks++;
                    if (bus_a.o_done !== 1'b0 || bus_a.o_zero_len !== 1'b1) begin
                        n_errors++;
                        $display("FAIL zero_len_after: done=%b zl=%b, expected 0 1", bus_a.o_done, bus_a.o_zero_len);
                    end
                end else begin
                    n_checks++;
                    if (bus_a.o_busy !== 1'b1 || bus_a.o_zero_len !== 1'b0) begin
                        n_errors++;
                        $display("FAIL dtt%0d_dir%0d_busy: busy=%b zl=%b, expected 1 0", d, dir, bus_a.o_busy, bus_a.o_zero_len);
                    end
                end
                bus_a.i_en = 1'b0;
                tick();
            end
        end
    endtask

    task automatic test_early_term();
        start_a(1'b0, 16'd4, 3'd0, 1'b0);
        for (int k = 1; k <= 18; k++) begin
            strobe_a(k == 5 || k == 18);
            if (k == 5) begin
                n_checks++;
                if (bus_a.o_busy !== 1'b1 || bus_a.o_early_term !== 1'b0) begin
                    n_errors++;
                    $display("FAIL term_midframe: busy=%b et=%b, expected 1 0", bus_a.o_busy, bus_a.o_early_term);
                end
            end
        end
        n_checks++;
        if (bus_a.o_busy !== 1'b0 || bus_a.o_early_term !== 1'b1 || bus_a.o_frames_left !== 17'd2) begin
            n_errors++;
            $display("FAIL term_boundary: busy=%b et=%b fl=%0d, expected 0 1 2",
                     bus_a.o_busy, bus_a.o_early_term, bus_a.o_frames_left);
        end
        tick();
        n_checks++;
        if (bus_a.o_done !== 1'b1 || bus_a.o_early_term !== 1'b1) begin
            n_errors++;
            $display("FAIL term_done: done=%b et=%b, expected 1 1", bus_a.o_done, bus_a.o_early_term);
        end
        bus_a.i_en = 1'b0;
        tick();
        start_a(1'b0, 16'd4, 3'd0, 1'b0);
        n_checks++;
        if (bus_a.o_early_term !== 1'b0) begin
            n_errors++;
            $display("FAIL term_clear_on_start: et=%b, expected 0", bus_a.o_early_term);
        end
        for (int k = 1; k <= 36; k++) strobe_a(k == 36);
        tick();
        n_checks++;
        if (bus_a.o_done !== 1'b1 || bus_a.o_early_term !== 1'b0 || bus_a.o_frames_left !== 17'd0) begin
            n_errors++;
            $display("FAIL term_last_frame: done=%b et=%b fl=%0d, expected 1 0 0",
                     bus_a.o_done, bus_a.o_early_term, bus_a.o_frames_left);
        end
        bus_a.i_en = 1'b0;
        tick();
    endtask

    task automatic test_abort_and_reset();
        int ndone;
        start_a(1'b0, 16'd3, 3'd0, 1'b0);
        for (int k = 1; k <= 5; k++) strobe_a(1'b0);
        bus_a.i_en = 1'b0;
        bus_a.i_scl_neg_edge = 1'b1;
        tick();
        bus_a.i_scl_neg_edge = 1'b0;
        n_checks++;
        if (bus_a.o_busy !== 1'b0 || bus_a.o_bit_idx !== 4'd5 || bus_a.o_frames_left !== 17'd3) begin
            n_errors++;
            $display("FAIL abort_hold: busy=%b bit=%0d fl=%0d, expected 0 5 3",
                     bus_a.o_busy, bus_a.o_bit_idx, bus_a.o_frames_left);
        end
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus_a.o_done) ndone++;
        end
        n_checks++;
        if (ndone != 0) begin
            n_errors++;
            $display("FAIL abort_no_done: done pulses=%0d, expected 0", ndone);
        end
        start_a(1'b0, 16'd3, 3'd0, 1'b0);
        for (int k = 1; k <= 4; k++) strobe_a(1'b0);
        rst_a = 1'b1;
        tick();
        n_checks++;
        if ({bus_a.o_busy, bus_a.o_bit_idx, bus_a.o_frames_left, bus_a.o_last_bit, bus_a.o_last_frame,
             bus_a.o_done, bus_a.o_early_term, bus_a.o_zero_len} !== '0) begin
            n_errors++;
            $display("FAIL reset_midcount: busy=%b bit=%0d fl=%0d, expected all 0",
                     bus_a.o_busy, bus_a.o_bit_idx, bus_a.o_frames_left);
        end
        tick();
        n_checks++;
        if (bus_a.o_busy !== 1'b0 || bus_a.o_frames_left !== 17'd0) begin
            n_errors++;
            $display("FAIL reset_priority: busy=%b fl=%0d with en high, expected 0 0", bus_a.o_busy, bus_a.o_frames_left);
        end
        bus_a.i_en = 1'b0;
        rst_a = 1'b0;
        tick();
    endtask

    task automatic test_frame18();
        bus_b.i_cmd_attr = 1'b0; bus_b.i_data_len = 16'd2; bus_b.i_dtt = 3'd0; bus_b.i_direct = 1'b0;
        bus_b.i_en = 1'b1;
        tick();
        for (int k = 1; k <= 17; k++) strobe_b();
        n_checks++;
        if (bus_b.o_bit_idx !== 5'd17 || bus_b.o_last_bit !== 1'b1 || bus_b.o_frames_left !== 17'd2) begin
            n_errors++;
            $display("FAIL f18_bit17: bit=%0d lb=%b fl=%0d, expected 17 1 2",
                     bus_b.o_bit_idx, bus_b.o_last_bit, bus_b.o_frames_left);
        end
        strobe_b();
        n_checks++;
        if (bus_b.o_bit_idx !== 5'd0 || bus_b.o_frames_left !== 17'd1 || bus_b.o_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL f18_frame1: bit=%0d fl=%0d busy=%b, expected 0 1 1",
                     bus_b.o_bit_idx, bus_b.o_frames_left, bus_b.o_busy);
        end
        for (int k = 1; k <= 18; k++) strobe_b();
        tick();
        n_checks++;
        if (bus_b.o_done !== 1'b1 || bus_b.o_busy !== 1'b0 || bus_b.o_frames_left !== 17'd0) begin
            n_errors++;
            $display("FAIL f18_done: done=%b busy=%b fl=%0d, expected 1 0 0",
                     bus_b.o_done, bus_b.o_busy, bus_b.o_frames_left);
        end
        bus_b.i_en = 1'b0;
        tick();
        bus_b.i_en = 1'b1;
        tick();
        for (int k = 1; k <= 3; k++) strobe_b();
        rst_b = 1'b1;
        tick();
        n_checks++;
        if ({bus_b.o_busy, bus_b.o_bit_idx, bus_b.o_frames_left, bus_b.o_done} !== '0) begin
            n_errors++;
            $display("FAIL f18_reset: busy=%b bit=%0d fl=%0d, expected all 0",
                     bus_b.o_busy, bus_b.o_bit_idx, bus_b.o_frames_left);
        end
        bus_b.i_en = 1'b0;
        rst_b = 1'b0;
        tick();
    endtask

    initial begin
        bus_a.i_en = 1'b0; bus_a.i_scl_neg_edge = 1'b0; bus_a.i_cmd_attr = 1'b0;
        bus_a.i_data_len = '0; bus_a.i_dtt = '0; bus_a.i_direct = 1'b0; bus_a.i_term = 1'b0;
        bus_b.i_en = 1'b0; bus_b.i_scl_neg_edge = 1'b0; bus_b.i_cmd_attr = 1'b0;
        bus_b.i_data_len = '0; bus_b.i_dtt = '0; bus_b.i_direct = 1'b0; bus_b.i_term = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        test_reset();
        test_regular_broadcast();
        test_regular_direct();
        test_dtt_sweep();
        test_early_term();
        test_abort_and_reset();
        test_frame18();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/frame_sequencer.md
# frame_sequencer

Parametrised frame counter for the I3C controller datapath. It counts SCL bit periods into frames and frames into a transfer. It derives the frame total from the command attributes: regular length, immediate DTT, and direct or broadcast addressing. It flags the last bit and last frame, terminates early when the target ends the read, and reports completion to the SDR/HDR control FSM. It sits beside the SCL generator and replaces the fixed-width frame/bit counter pair with one configurable block.

## Interface
- FRAME_BITS, 9, bits per frame: 9 for an SDR byte plus T-bit, 18 for an HDR-DDR word; legal range 2..32
- LEN_W, 16, width of the DATA_LEN field
- BIT_W, $clog2(FRAME_BITS), width of the bit index
- i_sys_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_en  in  1  level enable; a rising level in IDLE starts a transfer, and deassertion aborts it
- i_scl_neg_edge  in  1  one-cycle strobe that marks the end of one bit period
- i_cmd_attr  in  1  0 = regular, 1 = immediate
- i_data_len  in  LEN_W  frame count for regular commands
- i_dtt  in  3  data transfer type for immediate commands
- i_direct  in  1  1 = direct CCC, which adds one leading address frame; 0 = broadcast
- i_term  in  1  target T-bit end-of-data; sampled only at a frame boundary
- o_busy  out  1  high in COUNT
- o_bit_idx  out  BIT_W  current bit within the frame
- o_frames_left  out  LEN_W+1  frames remaining, including the current frame
- o_last_bit  out  1  COUNT and o_bit_idx == FRAME_BITS-1
- o_last_frame  out  1  COUNT and o_frames_left == 1
- o_done  out  1  one-cycle completion pulse
- o_early_term  out  1  set with o_done when the transfer ended on i_term; held until the next start
- o_zero_len  out  1  set with o_done when the frame total was 0; held until the next start

## Operation
- The FSM has four states: IDLE, COUNT, DONE and HOLD.
- **Frame total.** The total is computed combinationally and is LEN_W+1 bits wide, so it never overflows.
  - Regular: total = i_data_len + i_direct.
  - Immediate with DTT 0..4: total = DTT + i_direct.
  - Immediate with DTT 5..7: total = (DTT-3) + i_direct, i.e. one defining byte plus DTT-4 data frames.
- **IDLE.** When i_en = 1, the block latches the total into o_frames_left, clears o_bit_idx, clears the sticky flags, and moves to COUNT. If the total is 0, it moves to DONE instead and sets o_zero_len.
- **COUNT, on i_scl_neg_edge:**
  - If o_bit_idx < FRAME_BITS-1: o_bit_idx increments.
  - Otherwise (frame boundary): o_bit_idx goes to 0 and o_frames_left decrements. Then:
    - if o_frames_left was 1 → DONE;
    - else if i_term = 1 → DONE and o_early_term set;
    - else stay in COUNT.
- Without a strobe, the counters hold.
- **Last frame takes priority:** i_term on the last frame's boundary does not set o_early_term.
- **DONE.** o_done = 1 for exactly one cycle, then the FSM moves to HOLD.
- **HOLD.** The counters freeze. The FSM stays in HOLD until i_en = 0, then returns to IDLE, so a level enable cannot retrigger a transfer.
- **Abort.** i_en = 0 in COUNT returns the FSM to IDLE on the next edge. There is no o_done; the counters and sticky flags hold their last values.
- **Reset.** i_rst = 1 forces IDLE and clears every output to 0. Reset has priority over all other inputs in every state.

## Timing
- All outputs are registered except o_last_bit and o_last_frame, which are decoded from registered state.
- Start latency: i_en sampled high in IDLE at edge N gives o_busy = 1 after edge N.
- Bit timing: the strobe at edge M updates o_bit_idx after edge M.
- Completion: the strobe that ends the last frame at edge M gives o_done high for the single cycle after edge M+1.
- Zero-length: i_en at edge N gives o_done after edge N+1, and o_busy never rises.
- Simultaneous strobe and i_en fall in COUNT: the abort wins and the counters do not update.
- Inputs i_cmd_attr, i_data_len, i_dtt and i_direct are sampled only at the IDLE→COUNT edge; later changes are ignored.
- Wrap: o_frames_left never underflows. A strobe arriving in DONE or HOLD is ignored.

## Test plan
- **Regular broadcast.** Data_len = 2, FRAME_BITS = 9, 18 strobes → o_frames_left 2→1→0, o_last_frame high for strobes 10-18, one o_done, o_early_term = 0.
- **Regular direct.** Data_len = 5 → 6 frames (54 strobes), then o_done. i_en held high afterwards → the FSM stays in HOLD with no second start.
- **Immediate DTT sweep.** DTT 0..7 with i_direct = 0 and 1 → totals 0,1,2,3,4,2,3,4 (+1 when direct). DTT = 0 broadcast → o_zero_len = 1 and o_done one cycle after start, no strobes needed.
- **Early termination.** Data_len = 4, i_term = 1 at the boundary of frame 2 → o_done after 18 strobes with o_early_term = 1. The same stimulus on the last frame's boundary → o_early_term = 0.
- **Abort and reset.** i_en dropped after 5 strobes → IDLE, no o_done. Then i_rst mid-COUNT → all outputs 0 on the next cycle. Repeat with FRAME_BITS = 18: each frame ends after 18 strobes.
